panel_lamp_scanner: RTL and testbench

PANEL_LAMP_SCANNER -- requirements
Module: panel_lamp_scanner

---
 rtl/panel_lamp_scanner.sv | 150 +++++++++++++++
 tb/tb_panel_lamp_scanner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/panel_lamp_scanner.sv
// ---------------------------------------------------------------------------
// panel_lamp_scanner
//
// Multiplexes four 12-lamp rows of a front panel (program counter, data bus,
// instruction decode, status) onto a 4-row x 12-column lamp matrix. At the
// start of every frame the four lamp words are captured into shadow
// registers, so each frame shows one coherent snapshot. Each row slot lasts
// DWELL cycles. The first BLANK cycles of every slot are dark so that the
// row drivers can turn off before the column data changes.
//
// Parameters:
//   DWELL  SYSCLK cycles per row slot (>= BLANK+1, >= 8)
//   BLANK  dark cycles at the start of each row slot (>= 1)
//
// Ports:
//   SYSCLK       in   1   sole clock, rising edge
//   RESET        in   1   synchronous, active-high reset
//   pBusPC       in  12   program counter lamps
//   pBusData     in  12   data bus lamps
//   pInst        in   8   instruction lamps AND,TAD,ISZ,DCA,JMS,JMP,IOT,OPR
//   pStatus      in  12   miscellaneous status lamps
//   dim          in   3   brightness, 7 = full, 0 = 1/8 (PANEL_DIM_EN only)
//   lampRow      out  4   one-hot row select, active-high
//   lampCol      out 12   column drive, active-high, bit11 = leftmost lamp
//   frameStrobe  out  1   one-cycle pulse in the snapshot cycle
//
// Build option:
//   PANEL_DIM_EN  when defined, adds the dim input. During lit cycles the
//                 columns are driven only while cnt[2:0] <= dim. lampRow
//                 stays asserted for the whole lit portion of the slot.
// ---------------------------------------------------------------------------
module panel_lamp_scanner #(
    parameter int DWELL = 1024,
    parameter int BLANK = 16
) (
    input  logic        SYSCLK,
    input  logic        RESET,
    input  logic [11:0] pBusPC,
    input  logic [11:0] pBusData,
    input  logic [7:0]  pInst,
    input  logic [11:0] pStatus,
`ifdef PANEL_DIM_EN
    input  logic [2:0]  dim,
`endif
    output logic [3:0]  lampRow,
    output logic [11:0] lampCol,
    output logic        frameStrobe
);

    localparam int            CW       = $clog2(DWELL);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);

    // ST_HOLD is the single cycle spent at edge 0 of reset release. It keeps
    // every output dark, including frameStrobe, while cnt and row already
    // read zero. The cycle that follows is therefore the first snapshot.
    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    row, row_nxt;
    logic [11:0]   shadow0, shadow1, shadow2, shadow3;
    logic          snap;
    logic          lit;
    logic [11:0]   row_word;

    // State register and shadow capture
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state   <= ST_HOLD;
            cnt     <= '0;
            row     <= '0;
            shadow0 <= '0;
            shadow1 <= '0;
            shadow2 <= '0;
            shadow3 <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            row   <= row_nxt;
            // Inputs are sampled only here, so a frame can never mix old
            // and new values.
            if (snap) begin
                shadow0 <= pBusPC;
                shadow1 <= pBusData;
                shadow2 <= {pInst, 4'b0000};
                shadow3 <= pStatus;
            end
        end
    end

    // Next-state logic: slot counter and row sequencing
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        row_nxt   = row;
        case (state)
            ST_HOLD: begin
                state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    // Two-bit row wraps 3 -> 0 with no idle slot between frames.
                    row_nxt = row + 2'd1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_HOLD;
                cnt_nxt   = '0;
                row_nxt   = '0;
            end
        endcase
    end

    // Output decode, from registered state only (dim excepted)
    always_comb begin
        snap = (state == ST_SCAN) && (cnt == '0) && (row == 2'd0);
        lit  = (state == ST_SCAN) && (cnt >= BLANK_C);

        case (row)
            2'd0:    row_word = shadow0;
            2'd1:    row_word = shadow1;
            2'd2:    row_word = shadow2;
            default: row_word = shadow3;
        endcase

        frameStrobe = snap;
        lampRow     = 4'b0000;
        lampCol     = 12'h000;
        if (lit) begin
            lampRow = 4'b0001 << row;
`ifdef PANEL_DIM_EN
            // PWM within the slot: the low three bits of cnt act as an
            // 8-step phase. dim is applied directly, without a register.
            if (cnt[2:0] <= dim) begin
                lampCol = row_word;
            end
`else
            lampCol = row_word;
`endif
        end
    end

endmodule

// File: tb/tb_panel_lamp_scanner.sv
// ---------------------------------------------------------------------------
// tb_panel_lamp_scanner
//
// Directed bench for panel_lamp_scanner with DWELL=8, BLANK=2, so one frame
// is 32 cycles. The bench covers the following:
// - the reset state
// - the scan order
// - the timing of the frame strobe
// - snapshot coherency
// - the instruction row
// - an abort caused by reset in the middle of a frame
// - the one-hot and dark-column properties over random frames
// - dimming, when built with PANEL_DIM_EN
// ---------------------------------------------------------------------------
module tb_panel_lamp_scanner;

    localparam int DWELL = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DWELL;

    logic        SYSCLK = 1'b0;
    logic        RESET;
    logic [11:0] pBusPC;
    logic [11:0] pBusData;
    logic [7:0]  pInst;
    logic [11:0] pStatus;
`ifdef PANEL_DIM_EN
    logic [2:0]  dim;
`endif
    logic [3:0]  lampRow;
    logic [11:0] lampCol;
    logic        frameStrobe;

    int cmp  = 0;
    int errs = 0;

    panel_lamp_scanner #(.DWELL(DWELL), .BLANK(BLANK)) dut (
        .SYSCLK      (SYSCLK),
        .RESET       (RESET),
        .pBusPC      (pBusPC),
        .pBusData    (pBusData),
        .pInst       (pInst),
        .pStatus     (pStatus),
`ifdef PANEL_DIM_EN
        .dim         (dim),
`endif
        .lampRow     (lampRow),
        .lampCol     (lampCol),
        .frameStrobe (frameStrobe)
    );

    always #5 SYSCLK = ~SYSCLK;

    // Advance one clock; outputs are then sampled 2 time units after the edge.
    task automatic tick();
        @(posedge SYSCLK);
        #2;
    endtask

    task automatic chk(input string tag, input int c,
                       input logic [11:0] obs, input logic [11:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, obs, exp);
        end
    endtask

    // Expected outputs at cycle c of a frame whose snapshot is s0..s3.
    task automatic check_cycle(input int c, input logic [11:0] s0,
                               input logic [11:0] s1, input logic [11:0] s2,
                               input logic [11:0] s3);
        int          r;
        int          k;
        logic [11:0] sel;
        logic [3:0]  er;
        logic [11:0] ec;
        r  = c / DWELL;
        k  = c % DWELL;
        case (r)
            0:       sel = s0;
            1:       sel = s1;
            2:       sel = s2;
            default: sel = s3;
        endcase
        er = 4'b0000;
        ec = 12'h000;
        if (k >= BLANK) begin
            er = 4'(1 << r);
            ec = sel;
`ifdef PANEL_DIM_EN
            if ((k % 8) > int'(dim)) ec = 12'h000;
`endif
        end
        chk("frameStrobe", c, {11'b0, frameStrobe}, {11'b0, (c == 0)});
        chk("lampRow",     c, {8'b0, lampRow},      {8'b0, er});
        chk("lampCol",     c, lampCol,              ec);
    endtask

    // Runs one full frame from cycle 0 and checks it. If chg is set, pBusData
    // is changed to nd during cycle 5.
    task automatic run_frame(input logic [11:0] s0, input logic [11:0] s1,
                             input logic [11:0] s2, input logic [11:0] s3,
                             input bit chg, input logic [11:0] nd);
        for (int c = 0; c < FRAME; c++) begin
            tick();
            check_cycle(c, s0, s1, s2, s3);
            if (chg && c == 5) pBusData = nd;
        end
    endtask

    task automatic check_dark(input string tag);
        chk({tag, "_frameStrobe"}, -1, {11'b0, frameStrobe}, 12'h000);
        chk({tag, "_lampRow"},     -1, {8'b0, lampRow},      12'h000);
        chk({tag, "_lampCol"},     -1, lampCol,              12'h000);
    endtask

    initial begin
        RESET    = 1'b1;
        pBusPC   = 12'o7777;
        pBusData = 12'o0000;
        pInst    = 8'b0000_0000;
        pStatus  = 12'o0000;
`ifdef PANEL_DIM_EN
        dim      = 3'd7;
`endif

        // Reset held for three cycles; everything dark.
        repeat (3) tick();
        check_dark("reset");
        RESET = 1'b0;

        // Frame 0 snapshots PC=7777 and the rest 0. New values arrive mid-frame
        // and must not show until frame 1.
        for (int c = 0; c < FRAME; c++) begin
            tick();
            check_cycle(c, 12'o7777, 12'o0000, 12'o0000, 12'o0000);
            if (c == 5) begin
                pBusData = 12'o1234;
                pInst    = 8'b0000_0100;
                pStatus  = 12'o5252;
            end
        end

        // Frame 1 shows data 1234 and JMP in row 2. The data change at cycle 5
        // waits for frame 2.
        run_frame(12'o7777, 12'o1234, 12'b0000_0100_0000, 12'o5252, 1'b1, 12'o4321);
        run_frame(12'o7777, 12'o4321, 12'b0000_0100_0000, 12'o5252, 1'b0, 12'o0000);

        // Advance to row 2, cnt 5 (cycle 21), then assert reset.
        for (int c = 0; c <= 2 * DWELL + 5; c++) begin
            tick();
            check_cycle(c, 12'o7777, 12'o4321, 12'b0000_0100_0000, 12'o5252);
        end
        RESET = 1'b1;
        tick();
        check_dark("midreset");
        tick();
        RESET = 1'b0;
        run_frame(12'o7777, 12'o4321, 12'b0000_0100_0000, 12'o5252, 1'b0, 12'o0000);

        // 100 frames with random inputs: row one-hot (or zero), columns dark
        // whenever no row is driven.
        for (int f = 0; f < 100; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                pBusPC   = 12'($urandom);
                pBusData = 12'($urandom);
                pInst    = 8'($urandom);
                pStatus  = 12'($urandom);
                tick();
                chk("onehot", c, {11'b0, $onehot0(lampRow)}, 12'h001);
                if (lampRow == 4'b0000) chk("darkcol", c, lampCol, 12'h000);
            end
        end

`ifdef PANEL_DIM_EN
        pBusPC   = 12'o7777;
        pBusData = 12'o0000;
        pInst    = 8'b0000_0000;
        pStatus  = 12'o0000;
        dim      = 3'd1;
        run_frame(12'o7777, 12'o0000, 12'o0000, 12'o0000, 1'b0, 12'o0000);
        dim      = 3'd3;
        run_frame(12'o7777, 12'o0000, 12'o0000, 12'o0000, 1'b0, 12'o0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
